digit_step_ctrl: RTL and testbench

Run/pause/clear controller for the single-digit 7-segment counter path. It turns raw push-button levels into clean edge events and runs a 4-state FSM. It owns the prescaler that produces the 1 Hz step enable, and drives the BCD digit plus a blanking flag into the existing `bcd7seg` decoder. It replaces the free-running slow counter and flipper pair with a sequenced, user-controllable equivalent.

---
 rtl/digit_step_ctrl.sv | 152 +++++++++++++++
 tb/tb_digit_step_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/digit_step_ctrl.sv
// Run/pause/clear sequencer for the single-digit counter: debounced-level edge detect,
// 1 Hz step prescaler, pause blink, and BCD digit + blank flag for bcd7seg.
module digit_step_ctrl #(
  parameter int PRESCALE  = 50_000_000,
  parameter int MAX_DIGIT = 9
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       clear_btn,
  input  logic       up_dn,
  input  logic       one_shot,
  output logic [3:0] digit,
  output logic       tick,
  output logic       wrap,
  output logic       blank,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int PW   = $clog2(PRESCALE);
  localparam int HALF = PRESCALE / 2;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(HALF - 1);
  localparam logic [3:0]    MAX_D   = 4'(MAX_DIGIT);

  state_t        st;
  logic [PW-1:0] prescaler;
  logic [BW-1:0] blink_cnt;
  logic          start_prev, stop_prev, clear_prev;

  logic       clear_p, stop_p, start_p;
  logic       step_due, at_terminal, step_wrap;
  logic [3:0] stepped_digit, reload_digit;

  // Same-cycle priority: clear masks stop and start, stop masks start.
  assign clear_p = clear_btn & ~clear_prev;
  assign stop_p  = stop_btn & ~stop_prev & ~clear_p;
  assign start_p = start_btn & ~start_prev & ~clear_p & ~(stop_btn & ~stop_prev);

  assign step_due     = (prescaler == PS_LAST);
  assign at_terminal  = up_dn ? (digit == MAX_D) : (digit == 4'd0);
  assign reload_digit = up_dn ? 4'd0 : MAX_D;
  assign state        = st;

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    stepped_digit = digit;
    step_wrap     = 1'b0;
    if (up_dn) begin
      if (digit == MAX_D) begin
        stepped_digit = 4'd0;
        step_wrap     = 1'b1;
      end else begin
        stepped_digit = digit + 4'd1;
      end
    end else begin
      if (digit == 4'd0) begin
        stepped_digit = MAX_D;
        step_wrap     = 1'b1;
      end else begin
        stepped_digit = digit - 4'd1;
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      st         <= IDLE;
      digit      <= 4'd0;
      tick       <= 1'b0;
      wrap       <= 1'b0;
      blank      <= 1'b0;
      prescaler  <= '0;
      blink_cnt  <= '0;
      // Prev at 1 so a button already held through reset is not seen as a press.
      start_prev <= 1'b1;
      stop_prev  <= 1'b1;
      clear_prev <= 1'b1;
    end else begin
      start_prev <= start_btn;
      stop_prev  <= stop_btn;
      clear_prev <= clear_btn;
      tick       <= 1'b0;
      wrap       <= 1'b0;

      if (clear_p) begin
        st        <= IDLE;
        prescaler <= '0;
        digit     <= reload_digit;
        blank     <= 1'b0;
        blink_cnt <= '0;
      end else begin
        unique case (st)
          IDLE: begin
            if (start_p) st <= RUN;
          end

          RUN: begin
            if (step_due) begin
              prescaler <= '0;
              tick      <= 1'b1;
              if (one_shot && at_terminal) begin
                wrap <= 1'b1;
                st   <= DONE;
              end else begin
                digit <= stepped_digit;
                wrap  <= step_wrap;
                if (stop_p) st <= PAUSE;
              end
            end else begin
              prescaler <= prescaler + 1'b1;
              if (stop_p) st <= PAUSE;
            end
          end

          PAUSE: begin
            if (start_p) begin
              st        <= RUN;
              blank     <= 1'b0;
              blink_cnt <= '0;
            end else if (blink_cnt == BL_LAST) begin
              blink_cnt <= '0;
              blank     <= ~blank;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end

          DONE: begin
            if (start_p) begin
              st        <= RUN;
              digit     <= reload_digit;
              prescaler <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_digit_step_ctrl.sv
// Self-checking bench for digit_step_ctrl: directed scenarios then random button traffic,
// all compared against a cycle-counting reference model.
module tb_digit_step_ctrl;

  localparam int P  = 4;
  localparam int MD = 9;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic       CLOCK_50;
  logic       reset;
  logic       start_btn, stop_btn, clear_btn, up_dn, one_shot;
  logic [3:0] digit;
  logic       tick, wrap, blank;
  logic [1:0] state;

  digit_step_ctrl #(.PRESCALE(P), .MAX_DIGIT(MD)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .start_btn(start_btn),
    .stop_btn (stop_btn),
    .clear_btn(clear_btn),
    .up_dn    (up_dn),
    .one_shot (one_shot),
    .digit    (digit),
    .tick     (tick),
    .wrap     (wrap),
    .blank    (blank),
    .state    (state)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  // Reference model: RUN cycles since the last step, PAUSE cycles since entry.
  int m_state, m_digit, m_run, m_pause;
  bit m_tick, m_wrap;
  bit m_prev_start, m_prev_stop, m_prev_clear;

  task automatic model_edge();
    bit cp, tp, sp, at_end;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (reset) begin
      m_state = S_IDLE; m_digit = 0; m_run = 0; m_pause = 0;
      m_prev_start = 1'b1; m_prev_stop = 1'b1; m_prev_clear = 1'b1;
      return;
    end
    cp = clear_btn && !m_prev_clear;
    tp = stop_btn && !m_prev_stop && !cp;
    sp = start_btn && !m_prev_start && !cp && !(stop_btn && !m_prev_stop);
    m_prev_start = start_btn; m_prev_stop = stop_btn; m_prev_clear = clear_btn;
    if (cp) begin
      m_state = S_IDLE; m_run = 0; m_pause = 0;
      m_digit = up_dn ? 0 : MD;
    end else begin
      case (m_state)
        S_IDLE: if (sp) m_state = S_RUN;
        S_RUN: begin
          m_run++;
          if (m_run == P) begin
            m_run  = 0;
            m_tick = 1'b1;
            at_end = up_dn ? (m_digit == MD) : (m_digit == 0);
            if (one_shot && at_end) begin
              m_wrap  = 1'b1;
              m_state = S_DONE;
            end else begin
              m_wrap  = at_end;
              m_digit = up_dn ? (m_digit + 1) % (MD + 1) : (m_digit + MD) % (MD + 1);
            end
          end
          if (tp && m_state == S_RUN) m_state = S_PAUSE;
        end
        S_PAUSE: begin
          if (sp) begin m_state = S_RUN; m_pause = 0; end
          else m_pause++;
        end
        default: begin
          if (sp) begin m_state = S_RUN; m_digit = up_dn ? 0 : MD; m_run = 0; end
        end
      endcase
    end
  endtask

  function automatic int exp_blank();
    return (m_state == S_PAUSE) ? (m_pause / (P / 2)) % 2 : 0;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".state"}, 32'(state), 32'(m_state));
    check_val({tag, ".digit"}, 32'(digit), 32'(m_digit));
    check_val({tag, ".tick"},  32'(tick),  32'(m_tick));
    check_val({tag, ".wrap"},  32'(wrap),  32'(m_wrap));
    check_val({tag, ".blank"}, 32'(blank), 32'(exp_blank()));
  endtask

  task automatic cyc(input string tag);
    @(posedge CLOCK_50);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  task automatic wait_step_edge(input string tag);
    int i;
    for (i = 0; i < 2 * P && !(m_state == S_RUN && m_run == P - 1); i++) cyc(tag);
    check_val({tag, ".reach"}, 32'(m_state == S_RUN && m_run == P - 1), 32'd1);
  endtask

  initial begin
    int tcount, wcount, saved;
    reset = 1'b1; start_btn = 1'b1; stop_btn = 1'b0; clear_btn = 1'b0;
    up_dn = 1'b1; one_shot = 1'b0;

    // 1: start held through reset is not a press
    cycles(2, "reset");
    check_val("reset.state", 32'(state), 32'd0);
    check_val("reset.digit", 32'(digit), 32'd0);
    reset = 1'b0;
    cycles(2, "held");
    check_val("held.state", 32'(state), 32'(S_IDLE));
    start_btn = 1'b0; cyc("release");
    start_btn = 1'b1; cyc("press");
    check_val("press.state", 32'(state), 32'(S_RUN));
    start_btn = 1'b0;

    // 2: up count, ten ticks, single wrap on 9 -> 0
    tcount = 0; wcount = 0;
    for (int i = 0; i < 10 * P; i++) begin
      cyc("up");
      tcount += int'(tick);
      wcount += int'(wrap);
    end
    check_val("up.ticks", 32'(tcount), 32'd10);
    check_val("up.wraps", 32'(wcount), 32'd1);
    check_val("up.digit", 32'(digit), 32'd0);

    // 3: down one-shot to DONE, then restart
    up_dn = 1'b0; one_shot = 1'b1;
    clear_btn = 1'b1; cyc("dn.clr"); clear_btn = 1'b0; cyc("dn.clr0");
    check_val("dn.reload", 32'(digit), 32'd9);
    start_btn = 1'b1; cyc("dn.start"); start_btn = 1'b0;
    for (int i = 0; i < 12 * P && state !== 2'(S_DONE); i++) cyc("dn.run");
    check_val("dn.done", 32'(state), 32'(S_DONE));
    check_val("dn.hold0", 32'(digit), 32'd0);
    check_val("dn.tick", 32'(tick), 32'd1);
    check_val("dn.wrap", 32'(wrap), 32'd1);
    start_btn = 1'b1; cyc("dn.restart"); start_btn = 1'b0;
    check_val("dn.rdigit", 32'(digit), 32'd9);
    check_val("dn.rstate", 32'(state), 32'(S_RUN));
    cycles(P - 1, "dn.wait");
    cyc("dn.first");
    check_val("dn.ftick", 32'(tick), 32'd1);
    check_val("dn.fdigit", 32'(digit), 32'd8);

    // 4: pause, blink, resume
    up_dn = 1'b1; one_shot = 1'b0;
    clear_btn = 1'b1; cyc("pz.clr"); clear_btn = 1'b0; cyc("pz.clr0");
    start_btn = 1'b1; cyc("pz.start"); start_btn = 1'b0;
    cyc("pz.run");
    stop_btn = 1'b1; cyc("pz.stop"); stop_btn = 1'b0;
    check_val("pz.state", 32'(state), 32'(S_PAUSE));
    cycles(2, "pz.blink");
    check_val("pz.blank1", 32'(blank), 32'd1);
    cycles(2, "pz.blink");
    check_val("pz.blank0", 32'(blank), 32'd0);
    check_val("pz.frozen", 32'(digit), 32'd0);
    start_btn = 1'b1; cyc("pz.resume"); start_btn = 1'b0;
    check_val("pz.rblank", 32'(blank), 32'd0);
    cyc("pz.r1");
    check_val("pz.r1tick", 32'(tick), 32'd0);
    cyc("pz.r2");
    check_val("pz.r2tick", 32'(tick), 32'd1);

    // 5: same-cycle presses
    clear_btn = 1'b1; stop_btn = 1'b1; start_btn = 1'b1; cyc("same.all");
    check_val("same.all.state", 32'(state), 32'(S_IDLE));
    check_val("same.all.digit", 32'(digit), 32'd0);
    clear_btn = 1'b0; stop_btn = 1'b0; start_btn = 1'b0; cyc("same.idle");
    start_btn = 1'b1; cyc("same.go"); start_btn = 1'b0; cyc("same.go0");
    stop_btn = 1'b1; start_btn = 1'b1; cyc("same.ss");
    check_val("same.ss.state", 32'(state), 32'(S_PAUSE));
    stop_btn = 1'b0; start_btn = 1'b0; cyc("same.ss0");

    // 6: collisions with the step edge
    start_btn = 1'b1; cyc("col.resume"); start_btn = 1'b0;
    wait_step_edge("col.stopw");
    saved = m_digit;
    stop_btn = 1'b1; cyc("col.stop"); stop_btn = 1'b0;
    check_val("col.stop.tick", 32'(tick), 32'd1);
    check_val("col.stop.digit", 32'(digit), 32'((saved + 1) % (MD + 1)));
    check_val("col.stop.state", 32'(state), 32'(S_PAUSE));
    start_btn = 1'b1; cyc("col.resume2"); start_btn = 1'b0;
    wait_step_edge("col.clrw");
    clear_btn = 1'b1; cyc("col.clr"); clear_btn = 1'b0;
    check_val("col.clr.tick", 32'(tick), 32'd0);
    check_val("col.clr.digit", 32'(digit), 32'd0);

    // 7: reset mid-run with buttons held
    start_btn = 1'b1; cyc("mid.start"); cycles(3, "mid.run");
    stop_btn = 1'b1; reset = 1'b1; cyc("mid.reset");
    check_val("mid.state", 32'(state), 32'(S_IDLE));
    reset = 1'b0; start_btn = 1'b0; stop_btn = 1'b0; cyc("mid.rel");

    // 8: random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      start_btn = ($urandom_range(0, 5) == 0);
      stop_btn  = ($urandom_range(0, 13) == 0);
      clear_btn = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) up_dn = ~up_dn;
      if ($urandom_range(0, 49) == 0) one_shot = ~one_shot;
      cyc("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
